// File: rtl/seq_div_pkg.sv
// Shared constants and the FSM state type for the sequential divider.
package seq_div_pkg;

  // Default divisor/remainder width; dividend and quotient are twice this.
  localparam int DW_DEFAULT = 8;

  // Step counter width for the default width (counts 0 .. 2*DW-1).
  localparam int CW_DEFAULT = $clog2(2 * DW_DEFAULT);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/seq_div_step.sv
// One combinational restoring-division step: shift a dividend bit into the
// partial remainder, subtract the divisor if it fits.
module div_step #(
  parameter int DW = 8
) (
  input  logic [DW-1:0] rem_in,
  input  logic          din,
  input  logic [DW-1:0] dvs,
  output logic [DW-1:0] rem_out,
  output logic          q_bit
);

  // The trial value needs DW+1 bits; the stored remainder never does,
  // because after a step it is always strictly below the divisor.
  logic [DW:0] trial;

  assign trial = {rem_in, din};

  // Compare-and-restore; the difference is taken modulo 2^DW since it is
  // known to fit whenever the subtraction is chosen.
  always_comb begin
    q_bit   = 1'b0;
    rem_out = trial[DW-1:0];
    if (trial >= {1'b0, dvs}) begin
      q_bit   = 1'b1;
      rem_out = trial[DW-1:0] - dvs;
    end
  end

endmodule

// File: rtl/seq_div.sv
// Iterative restoring unsigned divider: 2*DW-bit dividend / DW-bit divisor,
// one quotient bit per clock, start/busy/done handshake.
module seq_div
  import seq_div_pkg::*;
#(
  parameter int DW = DW_DEFAULT
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [2*DW-1:0] dividend,
  input  logic [DW-1:0]   divisor,
  output logic            busy,
  output logic            done,
  output logic [2*DW-1:0] quotient,
  output logic [DW-1:0]   remainder,
  output logic            div_by_zero
);

  localparam int CW = $clog2(2 * DW);
  localparam logic [CW-1:0] LAST = CW'(2 * DW - 1);

  state_t state, state_nxt;

  // work holds the unconsumed dividend bits in its upper part and collects
  // quotient bits from the bottom, so after 2*DW shifts it is the quotient.
  logic [2*DW-1:0] work;
  logic [DW-1:0]   dvs_q;
  logic [DW-1:0]   prem;
  logic [CW-1:0]   cnt;

  logic [DW-1:0]   rem_nxt;
  logic            q_bit;
  logic            accept;

  assign accept = start && (state != ST_RUN);

  div_step #(.DW(DW)) u_step (
    .rem_in  (prem),
    .din     (work[2*DW-1]),
    .dvs     (dvs_q),
    .rem_out (rem_nxt),
    .q_bit   (q_bit)
  );

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  // Next-state: a zero divisor skips the iteration entirely.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE, ST_DONE: begin
        if (start) state_nxt = (divisor == '0) ? ST_DONE : ST_RUN;
        else       state_nxt = ST_IDLE;
      end
      ST_RUN:  if (cnt == LAST) state_nxt = ST_DONE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Handshake outputs decode directly from state.
  always_comb begin
    busy = (state == ST_RUN);
    done = (state == ST_DONE);
  end

  // Datapath: operand capture, one restoring step per RUN cycle, and the
  // result registers that only move on DONE entry.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      work        <= '0;
      dvs_q       <= '0;
      prem        <= '0;
      cnt         <= '0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else if (accept) begin
      if (divisor != '0) begin
        work        <= dividend;
        dvs_q       <= divisor;
        prem        <= '0;
        cnt         <= '0;
        div_by_zero <= 1'b0;
      end else begin
        quotient    <= '1;
        remainder   <= dividend[DW-1:0];
        div_by_zero <= 1'b1;
      end
    end else if (state == ST_RUN) begin
      work <= {work[2*DW-2:0], q_bit};
      prem <= rem_nxt;
      cnt  <= cnt + 1'b1;
      if (cnt == LAST) begin
        quotient  <= {work[2*DW-2:0], q_bit};
        remainder <= rem_nxt;
      end
    end
  end

endmodule

// File: tb/tb_seq_div.sv
// Self-checking bench for seq_div: directed cases plus a random sweep
// against plain integer division.
module tb_seq_div;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [15:0] dividend;
  logic [7:0]  divisor;
  logic        busy, done, div_by_zero;
  logic [15:0] quotient;
  logic [7:0]  remainder;

  int vectors = 0;
  int miscompares = 0;

  seq_div #(.DW(8)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  always #5 clk = ~clk;

  // Pulse start for one cycle, then wait (bounded) for done; returns the
  // number of negedges seen after the accepting edge and the busy count.
  task automatic run_op(input logic [15:0] a, input logic [7:0] b,
                        output int cyc, output int bcnt);
    @(negedge clk);
    start = 1'b1; dividend = a; divisor = b;
    @(negedge clk);
    start = 1'b0;
    cyc = 0; bcnt = 0;
    while (!done && cyc < 40) begin
      bcnt += busy;
      @(negedge clk);
      cyc++;
    end
  endtask

  task automatic test_reset;
    rst = 1'b1; start = 1'b0; dividend = '0; divisor = '0;
    repeat (3) @(negedge clk);
    vectors++;
    if ({busy, done, quotient, remainder, div_by_zero} !== '0) begin
      $display("FAIL reset: busy=%0b done=%0b q=%h r=%h dbz=%0b, want all 0",
               busy, done, quotient, remainder, div_by_zero);
      miscompares++;
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_basic;
    int cyc, bcnt;
    run_op(16'd140, 8'd14, cyc, bcnt);
    vectors++;
    if (cyc !== 16 || bcnt !== 16 || busy !== 1'b0) begin
      $display("FAIL basic_timing: cycles=%0d busy_cycles=%0d busy=%0b, want 16/16/0",
               cyc, bcnt, busy);
      miscompares++;
    end
    vectors++;
    if (quotient !== 16'd10 || remainder !== 8'd0 || div_by_zero !== 1'b0) begin
      $display("FAIL basic_result: q=%0d r=%0d dbz=%0b, want 10/0/0",
               quotient, remainder, div_by_zero);
      miscompares++;
    end
    @(negedge clk);
    vectors++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      $display("FAIL basic_done_pulse: done=%0b busy=%0b, want 0/0", done, busy);
      miscompares++;
    end
  endtask

  task automatic test_known;
    logic [15:0] a [3] = '{16'd2460, 16'd1000, 16'hFFFF};
    logic [7:0]  b [3] = '{8'h0A, 8'd7, 8'h01};
    logic [15:0] eq [3] = '{16'd246, 16'd142, 16'hFFFF};
    logic [7:0]  er [3] = '{8'd0, 8'd6, 8'd0};
    int cyc, bcnt;
    for (int i = 0; i < 3; i++) begin
      run_op(a[i], b[i], cyc, bcnt);
      vectors++;
      if (cyc !== 16 || quotient !== eq[i] || remainder !== er[i]) begin
        $display("FAIL known_%0d: cycles=%0d q=%0d r=%0d, want 16/%0d/%0d",
                 i, cyc, quotient, remainder, eq[i], er[i]);
        miscompares++;
      end
    end
  endtask

  task automatic test_div_zero;
    int cyc, bcnt;
    run_op(16'h04D2, 8'd0, cyc, bcnt);
    vectors++;
    if (cyc !== 0 || bcnt !== 0 || busy !== 1'b0) begin
      $display("FAIL div0_timing: cycles=%0d busy_cycles=%0d, want 0/0", cyc, bcnt);
      miscompares++;
    end
    vectors++;
    if (quotient !== 16'hFFFF || remainder !== 8'hD2 || div_by_zero !== 1'b1) begin
      $display("FAIL div0_result: q=%h r=%h dbz=%0b, want ffff/d2/1",
               quotient, remainder, div_by_zero);
      miscompares++;
    end
    @(negedge clk);
  endtask

  task automatic test_back_to_back;
    int cyc;
    @(negedge clk);
    start = 1'b1; dividend = 16'hFFFF; divisor = 8'hFF;
    @(negedge clk);
    start = 1'b0;
    cyc = 0;
    while (!done && cyc < 40) begin
      if (cyc == 4) begin
        start = 1'b1; dividend = 16'h1234; divisor = 8'h05;
      end else begin
        start = 1'b0; dividend = 16'($urandom); divisor = 8'($urandom);
      end
      @(negedge clk);
      cyc++;
    end
    start = 1'b0;
    vectors++;
    if (cyc !== 16 || quotient !== 16'd257 || remainder !== 8'd0) begin
      $display("FAIL ignore_start: cycles=%0d q=%0d r=%0d, want 16/257/0",
               cyc, quotient, remainder);
      miscompares++;
    end
    // Request during the DONE cycle.
    start = 1'b1; dividend = 16'd100; divisor = 8'd3;
    @(negedge clk);
    start = 1'b0;
    vectors++;
    if (busy !== 1'b1 || done !== 1'b0 || quotient !== 16'd257) begin
      $display("FAIL b2b_accept: busy=%0b done=%0b q=%0d, want 1/0/257 (held)",
               busy, done, quotient);
      miscompares++;
    end
    cyc = 0;
    while (!done && cyc < 40) begin
      @(negedge clk);
      cyc++;
    end
    vectors++;
    if (cyc !== 16 || quotient !== 16'd33 || remainder !== 8'd1) begin
      $display("FAIL b2b_result: cycles=%0d q=%0d r=%0d, want 16/33/1",
               cyc, quotient, remainder);
      miscompares++;
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid_run;
    int cyc, bcnt, seen_done;
    @(negedge clk);
    start = 1'b1; dividend = 16'd200; divisor = 8'd7;
    @(negedge clk);
    start = 1'b0;
    repeat (7) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    vectors++;
    if ({busy, done, quotient, remainder, div_by_zero} !== '0) begin
      $display("FAIL reset_mid: busy=%0b done=%0b q=%h r=%h dbz=%0b, want all 0",
               busy, done, quotient, remainder, div_by_zero);
      miscompares++;
    end
    seen_done = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      seen_done += done;
      if (i == 3) rst = 1'b0;
    end
    vectors++;
    if (seen_done !== 0) begin
      $display("FAIL reset_no_done: done pulses=%0d, want 0", seen_done);
      miscompares++;
    end
    run_op(16'd140, 8'd14, cyc, bcnt);
    vectors++;
    if (cyc !== 16 || quotient !== 16'd10 || remainder !== 8'd0) begin
      $display("FAIL reset_recover: cycles=%0d q=%0d r=%0d, want 16/10/0",
               cyc, quotient, remainder);
      miscompares++;
    end
  endtask

  task automatic test_random;
    int cyc, bcnt;
    int unsigned a, b, eq, er;
    for (int n = 0; n < 1000; n++) begin
      a = $urandom_range(0, 65535);
      b = $urandom_range(1, 255);
      eq = a / b;
      er = a % b;
      run_op(16'(a), 8'(b), cyc, bcnt);
      vectors++;
      if (cyc !== 16 || quotient !== 16'(eq) || remainder !== 8'(er) ||
          int'(quotient) * int'(b) + int'(remainder) != int'(a) ||
          int'(remainder) >= int'(b)) begin
        $display("FAIL random %0d/%0d: cycles=%0d q=%0d r=%0d, want 16/%0d/%0d",
                 a, b, cyc, quotient, remainder, eq, er);
        miscompares++;
      end
    end
  endtask

  initial begin
    test_reset;
    test_basic;
    test_known;
    test_div_zero;
    test_back_to_back;
    test_reset_mid_run;
    test_random;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
